// File: rtl/rlc_game_switch_debouncer_if.sv
// rtl/rlc_game_switch_debouncer_if.sv - switch bus between board pins, debouncer and its consumers
//
// Purpose: bundles the raw switch input and the conditioned outputs of the
//          switch debouncer so the block and its environment share one port.
// Signals:
//   switches_raw  raw asynchronous switch pins (driven by the master side)
//   debounced     debounced switch level, feeds the PIO in_port
//   rise_pulse    one-cycle pulse per bit on a debounced 0->1 transition
//   fall_pulse    one-cycle pulse per bit on a debounced 1->0 transition
//   any_change    one-cycle pulse when any rise/fall pulse bit is set
// Modports:
//   master  board/environment side: drives switches_raw, observes outputs
//   slave   debouncer side: samples switches_raw, drives outputs

interface rlc_game_switch_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] switches_raw;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             any_change;

    modport master (
        output switches_raw,
        input  debounced,
        input  rise_pulse,
        input  fall_pulse,
        input  any_change
    );

    modport slave (
        input  switches_raw,
        output debounced,
        output rise_pulse,
        output fall_pulse,
        output any_change
    );
endinterface

// File: rtl/rlc_game_switch_debouncer.sv
// rtl/rlc_game_switch_debouncer.sv - per-bit synchronizer and stability-counter switch debouncer
//
// Purpose: synchronizes each raw switch bit through two flops, then only lets
//          the debounced level follow once the synchronized value has differed
//          from it for DEBOUNCE_CYCLES consecutive cycles. Emits one-cycle
//          rise/fall pulses and a combined any_change pulse on each update.
// Parameters:
//   WIDTH            number of switch bits
//   DEBOUNCE_CYCLES  consecutive differing cycles required to accept a level (>= 2)
//   CNT_W            stability counter width (>= $clog2(DEBOUNCE_CYCLES))
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   sw       slave modport: switches_raw in; debounced, rise_pulse,
//            fall_pulse, any_change out (all registered)

module rlc_game_switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                        clk,
    input  logic                        reset_n,
    rlc_game_switch_debouncer_if.slave  sw
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] debounced_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             any_change_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];

    logic [WIDTH-1:0] debounced_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Next-state per bit. The counter only runs while sync2 disagrees with
    // the debounced level, so any return to agreement discards partial
    // progress; reaching CNT_LAST commits the new level and resets the count,
    // which also keeps the counter from ever exceeding CNT_LAST.
    always_comb begin
        debounced_d = debounced_q;
        rise_d      = '0;
        fall_d      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2[i] != debounced_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    debounced_d[i] = sync2[i];
                    rise_d[i]      = sync2[i];
                    fall_d[i]      = ~sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= '0;
            sync2        <= '0;
            debounced_q  <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            any_change_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1        <= sw.switches_raw;
            sync2        <= sync1;
            debounced_q  <= debounced_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            // Computed from the same next-state as the pulses so it lines up
            // with them in the same cycle.
            any_change_q <= |(rise_d | fall_d);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw.debounced  = debounced_q;
    assign sw.rise_pulse = rise_q;
    assign sw.fall_pulse = fall_q;
    assign sw.any_change = any_change_q;

endmodule

// File: tb/tb_rlc_game_switch_debouncer.sv
// tb/tb_rlc_game_switch_debouncer.sv - directed-vector bench for rlc_game_switch_debouncer

module tb_rlc_game_switch_debouncer;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;
    localparam int CW    = 3;

    logic clk;
    logic reset_n;

    int n_vec;
    int n_bad;

    rlc_game_switch_debouncer_if #(.WIDTH(WIDTH)) sw_if ();

    rlc_game_switch_debouncer #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] deb, input logic [7:0] rise,
                              input logic [7:0] fall, input logic any);
        check_val({tag, ".deb"},  32'(sw_if.debounced),  32'(deb));
        check_val({tag, ".rise"}, 32'(sw_if.rise_pulse), 32'(rise));
        check_val({tag, ".fall"}, 32'(sw_if.fall_pulse), 32'(fall));
        check_val({tag, ".any"},  32'(sw_if.any_change), 32'(any));
    endtask

    // raw has just been changed; expect old level for 5 edges, new level with
    // pulses on the 6th edge, and pulses gone on the 7th.
    task automatic expect_qualify(input string tag, input logic [7:0] old_deb, input logic [7:0] new_deb,
                                  input logic [7:0] rise, input logic [7:0] fall);
        for (int k = 0; k < DEB + 1; k++) begin
            step();
            check_outs({tag, ".wait"}, old_deb, 8'h00, 8'h00, 1'b0);
        end
        step();
        check_outs({tag, ".edge"}, new_deb, rise, fall, 1'b1);
        step();
        check_outs({tag, ".after"}, new_deb, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset_n = 1'b0;
        sw_if.switches_raw = 8'h00;

        // Reset state
        #2;
        check_outs("rst", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        step();
        check_outs("rst_clk", 8'h00, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b1;
        step();
        check_outs("idle", 8'h00, 8'h00, 8'h00, 1'b0);

        // Single bit rise, 6-edge latency
        sw_if.switches_raw = 8'h01;
        expect_qualify("rise0", 8'h00, 8'h01, 8'h01, 8'h00);

        // 3-cycle low glitch is rejected
        sw_if.switches_raw = 8'h00;
        step(); step(); step();
        sw_if.switches_raw = 8'h01;
        for (int k = 0; k < 8; k++) begin
            check_outs("glitch3", 8'h01, 8'h00, 8'h00, 1'b0);
            step();
        end

        // 4-cycle low is accepted
        sw_if.switches_raw = 8'h00;
        expect_qualify("fall0", 8'h01, 8'h00, 8'h00, 8'h01);

        // Multi-bit simultaneous rise
        sw_if.switches_raw = 8'hA5;
        expect_qualify("riseA5", 8'h00, 8'hA5, 8'hA5, 8'h00);

        // Chatter on bit3 for 20 cycles, then held high
        for (int k = 0; k < 20; k++) begin
            sw_if.switches_raw = (k % 2 == 0) ? 8'hAD : 8'hA5;
            step();
            check_outs("chatter", 8'hA5, 8'h00, 8'h00, 1'b0);
        end
        sw_if.switches_raw = 8'hAD;
        expect_qualify("chat_end", 8'hA5, 8'hAD, 8'h08, 8'h00);

        // Reset mid-count with raw=FF (counters for changing bits at 2)
        sw_if.switches_raw = 8'hFF;
        step(); step(); step(); step();
        check_outs("pre_rst", 8'hAD, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b0;
        #1;
        check_outs("async_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        step();
        check_outs("rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b1;
        expect_qualify("relFF", 8'h00, 8'hFF, 8'hFF, 8'h00);

        // Fall to 00, then rise to 3C and hold 100 cycles
        sw_if.switches_raw = 8'h00;
        expect_qualify("fallFF", 8'hFF, 8'h00, 8'h00, 8'hFF);
        sw_if.switches_raw = 8'h3C;
        expect_qualify("rise3C", 8'h00, 8'h3C, 8'h3C, 8'h00);
        for (int k = 0; k < 100; k++) begin
            step();
            check_outs("hold3C", 8'h3C, 8'h00, 8'h00, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
